tournament_predictor_n: RTL

// - Parametrised two-level tournament branch predictor. A per-PC chooser table selects between a gshare PHT and a bimodal PHT.
// - Owns the speculative global history register (GHR) and restores it on a branch miss.
// - Clears all tables with a sequential init walk after reset.
// - Sits between fetch (predict port) and branch resolution (update/miss port).

---
 rtl/tp_pkg.sv | 16 +
 rtl/tp_counter_table.sv | 31 +++
 rtl/tournament_predictor_n.sv | 111 +++++++++++
 3 files changed

// File: rtl/tp_pkg.sv
// tp_pkg: shared counter constants, saturating helpers and FSM state for the tournament predictor
package tp_pkg;
  typedef enum logic {INIT, RUN} state_t;
  function automatic int ctr_reset_val(int w);
    return (1 << (w - 1)) - 1;
  endfunction
  function automatic int ctr_max_val(int w);
    return (1 << w) - 1;
  endfunction
  function automatic int sat_inc(int v, int w);
    return v >= ctr_max_val(w) ? v : v + 1;
  endfunction
  function automatic int sat_dec(int v);
    return v <= 0 ? 0 : v - 1;
  endfunction
endpackage

// File: rtl/tp_counter_table.sv
// tp_counter_table: saturating counter table, async read, sync update, init-walk write port
module tp_counter_table
  import tp_pkg::*;
#(
  parameter int INDEX_LEN = 7,
  parameter int CTR_WIDTH = 2,
  parameter int INIT_LEN  = 8
) (
  input  logic                 clk,
  input  logic                 init_en,
  input  logic [INIT_LEN-1:0]  init_idx,
  input  logic [INDEX_LEN-1:0] rd_idx,
  output logic [CTR_WIDTH-1:0] rd_ctr,
  input  logic                 upd_en,
  input  logic [INDEX_LEN-1:0] upd_idx,
  input  logic                 upd_up
);
  localparam logic [CTR_WIDTH-1:0] CTR_RST = CTR_WIDTH'(ctr_reset_val(CTR_WIDTH));
  logic [CTR_WIDTH-1:0] mem [2**INDEX_LEN];
  logic [CTR_WIDTH-1:0] upd_cur, upd_nxt;
  logic                 init_hit;
  assign rd_ctr   = mem[rd_idx];
  assign upd_cur  = mem[upd_idx];
  assign upd_nxt  = upd_up ? CTR_WIDTH'(sat_inc(int'(upd_cur), CTR_WIDTH))
                           : CTR_WIDTH'(sat_dec(int'(upd_cur)));
  // walk index may exceed this table's depth when another table is larger
  assign init_hit = init_en && (int'(init_idx) < (2**INDEX_LEN));
  always_ff @(posedge clk)
    if (init_hit) mem[init_idx[INDEX_LEN-1:0]] <= CTR_RST;
    else if (upd_en) mem[upd_idx] <= upd_nxt;
endmodule

// File: rtl/tournament_predictor_n.sv
// tournament_predictor_n: chooser-selected gshare/bimodal predictor with speculative GHR and init walk.
// Define TP_PERF_COUNTERS_EN to enable the update/mispredict performance counters.
module tournament_predictor_n
  import tp_pkg::*;
#(
  parameter int PC_WIDTH      = 16,
  parameter int GHR_LEN       = 8,
  parameter int PHT_INDEX_LEN = 8,
  parameter int BIM_INDEX_LEN = 7,
  parameter int CHO_INDEX_LEN = 7,
  parameter int CTR_WIDTH     = 2
) (
  input  logic                clk,
  input  logic                reset,
  output logic                ready,
  input  logic                predict_enable,
  input  logic [PC_WIDTH-1:0] pc_bits_read,
  output logic                pred_valid,
  output logic                prediction,
  output logic                pred_gshare,
  output logic                pred_bimodal,
  output logic [GHR_LEN-1:0]  pred_ghr,
  input  logic                update_valid,
  input  logic [PC_WIDTH-1:0] pc_bits_write,
  input  logic                outcome,
  input  logic [GHR_LEN-1:0]  update_ghr,
  input  logic                update_gshare,
  input  logic                update_bimodal,
  input  logic                update_final,
  input  logic                branch_miss,
  output logic [31:0]         perf_updates,
  output logic [31:0]         perf_misses
);
  localparam int W1       = PHT_INDEX_LEN > BIM_INDEX_LEN ? PHT_INDEX_LEN : BIM_INDEX_LEN;
  localparam int WALK_LEN = W1 > CHO_INDEX_LEN ? W1 : CHO_INDEX_LEN;
  localparam int MSB      = CTR_WIDTH - 1;
  state_t                state;
  logic [WALK_LEN-1:0]   walk_idx;
  logic [GHR_LEN-1:0]    ghr;
  logic [CTR_WIDTH-1:0]  g_ctr, b_ctr, c_ctr;
  logic                  init_en, pred_acc, upd_acc, miss_acc, final_pred, unused_bits;
  assign init_en     = state == INIT;
  assign pred_acc    = ready & predict_enable;
  assign upd_acc     = ready & update_valid;
  assign miss_acc    = ready & branch_miss;
  assign final_pred  = c_ctr[MSB] ? g_ctr[MSB] : b_ctr[MSB];
  assign unused_bits = ^{pc_bits_read, pc_bits_write, update_final};
  tp_counter_table #(.INDEX_LEN(PHT_INDEX_LEN), .CTR_WIDTH(CTR_WIDTH), .INIT_LEN(WALK_LEN)) u_gshare (
    .clk(clk), .init_en(init_en), .init_idx(walk_idx),
    .rd_idx(pc_bits_read[PHT_INDEX_LEN-1:0] ^ PHT_INDEX_LEN'(ghr)), .rd_ctr(g_ctr),
    .upd_en(upd_acc), .upd_idx(pc_bits_write[PHT_INDEX_LEN-1:0] ^ PHT_INDEX_LEN'(update_ghr)),
    .upd_up(outcome)
  );
  tp_counter_table #(.INDEX_LEN(BIM_INDEX_LEN), .CTR_WIDTH(CTR_WIDTH), .INIT_LEN(WALK_LEN)) u_bimodal (
    .clk(clk), .init_en(init_en), .init_idx(walk_idx),
    .rd_idx(pc_bits_read[BIM_INDEX_LEN-1:0]), .rd_ctr(b_ctr),
    .upd_en(upd_acc), .upd_idx(pc_bits_write[BIM_INDEX_LEN-1:0]), .upd_up(outcome)
  );
  // chooser trains only when the components disagree; up means gshare was right
  tp_counter_table #(.INDEX_LEN(CHO_INDEX_LEN), .CTR_WIDTH(CTR_WIDTH), .INIT_LEN(WALK_LEN)) u_chooser (
    .clk(clk), .init_en(init_en), .init_idx(walk_idx),
    .rd_idx(pc_bits_read[CHO_INDEX_LEN-1:0]), .rd_ctr(c_ctr),
    .upd_en(upd_acc & (update_gshare != update_bimodal)),
    .upd_idx(pc_bits_write[CHO_INDEX_LEN-1:0]), .upd_up(update_gshare == outcome)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= INIT;
      walk_idx     <= '0;
      ready        <= 1'b0;
      ghr          <= '0;
      pred_valid   <= 1'b0;
      prediction   <= 1'b0;
      pred_gshare  <= 1'b0;
      pred_bimodal <= 1'b0;
      pred_ghr     <= '0;
    end else begin
      pred_valid <= pred_acc;
      if (state == INIT) begin
        walk_idx <= walk_idx + WALK_LEN'(1);
        if (&walk_idx) begin
          state <= RUN;
          ready <= 1'b1;
        end
      end
      if (pred_acc) begin
        prediction   <= final_pred;
        pred_gshare  <= g_ctr[MSB];
        pred_bimodal <= b_ctr[MSB];
        pred_ghr     <= ghr;
      end
      // a miss repairs history and overrides the speculative shift
      if (miss_acc) ghr <= {update_ghr[GHR_LEN-2:0], outcome};
      else if (pred_acc) ghr <= {ghr[GHR_LEN-2:0], final_pred};
    end
  end
`ifdef TP_PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_updates <= '0;
      perf_misses  <= '0;
    end else if (upd_acc) begin
      perf_updates <= perf_updates + 32'd1;
      perf_misses  <= perf_misses + 32'(update_final != outcome);
    end
  end
`else
  assign perf_updates = '0;
  assign perf_misses  = '0;
`endif
endmodule
